// File: rtl/mem_access_stage.sv
// MEM-stage data access unit: holds the data memory and performs byte/half/word loads and stores
// with WAIT_STATES stall cycles. Define MEM_STALL_COUNT_EN to add the saturating stallCount output.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  memSize,
  input  logic        loadSigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        misaligned
`ifdef MEM_STALL_COUNT_EN
  ,
  output logic [31:0] stallCount
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, nextState;
  logic [3:0]  waitCnt, nextWaitCnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] wordIdx;
  logic [31:0] memWord, shifted, loadVal, storeData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [3:0]  byteEn;
  logic        isByte, isHalf, req, complete;

  assign isByte  = (memSize == 2'b00);
  assign isHalf  = (memSize == 2'b01);
  assign wordIdx = address[AW+1:2];
  assign memWord = mem[wordIdx];

  assign misaligned = ~rst & (MemRead | MemWrite) &
                      ((isHalf & address[0]) | (~isByte & ~isHalf & (address[1:0] != 2'b00)));
  // rst gating here also keeps a zero-wait access from completing while reset is held
  assign req = (MemRead | MemWrite) & ~misaligned & ~rst;

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    memStall    = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WS == 4'd0) begin
            complete = 1'b1;
          end else begin
            memStall    = 1'b1;
            nextWaitCnt = 4'd1;
            nextState   = (WS == 4'd1) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        // waitCnt holds the stall cycles already spent, the IDLE acceptance cycle included
        memStall    = 1'b1;
        nextWaitCnt = waitCnt + 4'd1;
        if (nextWaitCnt == WS) nextState = DONE;
      end
      DONE: begin
        complete    = req;
        nextState   = IDLE;
        nextWaitCnt = 4'd0;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  always_comb begin
    byteEn    = 4'b0000;
    storeData = writeData;
    if (isByte) begin
      byteEn[address[1:0]] = 1'b1;
      storeData = {4{writeData[7:0]}};
    end else if (isHalf) begin
      byteEn    = address[1] ? 4'b1100 : 4'b0011;
      storeData = {2{writeData[15:0]}};
    end else begin
      byteEn = 4'b1111;
    end
  end

  // Memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (complete && MemWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  assign shifted  = memWord >> {address[1:0], 3'b000};
  assign loadByte = shifted[7:0];
  assign loadHalf = address[1] ? memWord[31:16] : memWord[15:0];

  always_comb begin
    case (memSize)
      2'b00:   loadVal = {{24{loadSigned & loadByte[7]}}, loadByte};
      2'b01:   loadVal = {{16{loadSigned & loadHalf[15]}}, loadHalf};
      default: loadVal = memWord;
    endcase
  end

  assign readData = (complete && MemRead && !MemWrite) ? loadVal : 32'h0;

`ifdef MEM_STALL_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= 32'h0;
    end else if (memStall && stallCount != 32'hFFFF_FFFF) begin
      stallCount <= stallCount + 32'h1;
    end
  end
`endif

endmodule
